// File: rtl/ps2_rx_controller.sv
// PS/2 receive controller: edge-driven frame sequencer, conditioning config register, receive FIFO with valid/ready host port.
// Byte visible 1 clk after the stop-bit fall; a full FIFO drops good bytes (overflow pulse). PS2_RX_TIMEOUT_EN adds a stalled-frame timeout.
module ps2_rx_controller #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter logic [4:0]  DEB_RESET      = 5'd4,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       enable,
  input  logic       cfg_we,
  input  logic [5:0] cfg_wdata,
  output logic       synch_en,
  output logic [4:0] deb_time,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       busy,
  output logic       frame_err,
  output logic       overflow
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("ps2_rx_controller: FIFO_DEPTH must be a power of 2 >= 2 and TIMEOUT_CYCLES >= 2");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t         state;
  state_t         next_state;
  logic           prev_clk;
  logic           fall;
  logic [2:0]     bit_cnt;
  logic [7:0]     shreg;
  logic           par;
  logic [7:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic           full;
  logic           push;
  logic           pop;
  logic           err_set;
  logic           ovf_set;
  logic           start_en;
  logic           shift_en;
  logic           par_en;
  logic           timeout_hit;

  assign fall     = prev_clk & ~ps2_clk;
  assign full     = (count == CW'(FIFO_DEPTH));
  assign rx_valid = (count != '0);
  assign pop      = rx_valid & rx_ready;
  assign rx_data  = mem[rd_ptr];
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Abort sources (disable, config write) outrank the edge; the edge outranks the timeout.
  always_comb begin
    next_state = state;
    push       = 1'b0;
    err_set    = 1'b0;
    ovf_set    = 1'b0;
    start_en   = 1'b0;
    shift_en   = 1'b0;
    par_en     = 1'b0;
    if (!enable || cfg_we) begin
      next_state = IDLE;
    end else if (fall) begin
      case (state)
        IDLE: begin
          if (!ps2_data) begin
            next_state = DATA;
            start_en   = 1'b1;
          end
        end
        DATA: begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) begin
            next_state = PARITY;
          end
        end
        PARITY: begin
          par_en     = 1'b1;
          next_state = STOP;
        end
        STOP: begin
          next_state = IDLE;
          if (ps2_data && (^{shreg, par})) begin
            // A simultaneous pop frees a slot, so a full FIFO still accepts the byte.
            if (!full || pop) begin
              push = 1'b1;
            end else begin
              ovf_set = 1'b1;
            end
          end else begin
            err_set = 1'b1;
          end
        end
        default: next_state = IDLE;
      endcase
    end else if (timeout_hit) begin
      next_state = IDLE;
      err_set    = 1'b1;
    end
  end

`ifdef PS2_RX_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;

  assign timeout_hit = (state != IDLE) && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (fall || state == IDLE || next_state == IDLE) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_clk  <= 1'b1;
      bit_cnt   <= '0;
      shreg     <= '0;
      par       <= 1'b0;
      synch_en  <= 1'b1;
      deb_time  <= DEB_RESET;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      prev_clk  <= ps2_clk;
      frame_err <= err_set;
      overflow  <= ovf_set;
      if (cfg_we) begin
        synch_en <= cfg_wdata[5];
        deb_time <= cfg_wdata[4:0];
      end
      if (start_en) begin
        bit_cnt <= '0;
      end
      if (shift_en) begin
        shreg   <= {ps2_data, shreg[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (par_en) begin
        par <= ps2_data;
      end
    end
  end

  // Storage is cleared on reset so rx_data reads zero while empty after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_rx_controller.sv
// Randomised scoreboard bench for ps2_rx_controller: frame-level reference model plus per-cycle output monitor.
module tb_ps2_rx_controller;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic       enable;
  logic       cfg_we;
  logic [5:0] cfg_wdata;
  logic       synch_en;
  logic [4:0] deb_time;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       busy;
  logic       frame_err;
  logic       overflow;

  always #5 clk = ~clk;

  ps2_rx_controller #(.FIFO_DEPTH(DEPTH), .DEB_RESET(5'd4)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .enable(enable), .cfg_we(cfg_we), .cfg_wdata(cfg_wdata),
    .synch_en(synch_en), .deb_time(deb_time), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .busy(busy),
    .frame_err(frame_err), .overflow(overflow)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bytes the receiver should hold, in order, plus pending pulse expectations.
  logic [7:0] mq[$];
  logic       mon_on  = 1'b0;
  logic       exp_err = 1'b0;
  logic       exp_ovf = 1'b0;
  logic       ev_vld  = 1'b0;
  logic       ev_good = 1'b0;
  logic [7:0] ev_byte = 8'h00;
  logic       rand_ready = 1'b0;

  always @(negedge clk) begin
    if (mon_on) begin
      logic [7:0] head;
      chk("rx_valid", rx_valid, mq.size() > 0);
      chk("frame_err", frame_err, exp_err);
      chk("overflow", overflow, exp_ovf);
      if (mq.size() > 0 && rx_ready) begin
        head = mq.pop_front();
        chk("rx_data", rx_data, head);
      end
      exp_err = 1'b0;
      exp_ovf = 1'b0;
      if (ev_vld) begin
        ev_vld = 1'b0;
        if (!ev_good)               exp_err = 1'b1;
        else if (mq.size() >= DEPTH) exp_ovf = 1'b1;
        else                        mq.push_back(ev_byte);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      step();
      if (rand_ready) rx_ready = 1'($urandom_range(0, 1));
    end
  end

  // One PS/2 bit cell; the falling edge is seen by the DUT in the cycle ps2_clk drops.
  task automatic ps2_bit(input logic b, input logic last, input logic [7:0] d,
                         input logic good, input logic pop_stop);
    step();
    ps2_data = b;
    step();
    step();
    ps2_clk = 1'b0;
    if (last) begin
      ev_byte = d;
      ev_good = good;
      ev_vld  = 1'b1;
      if (pop_stop) rx_ready = 1'b1;
    end
    step();
    if (last && pop_stop) rx_ready = 1'b0;
    step();
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_ok, input logic stop_bit,
                            input logic pop_stop);
    logic p;
    logic good;
    p    = (($countones(d) % 2) == 0) ? par_ok : ~par_ok;
    good = stop_bit && ((($countones(d) + int'(p)) % 2) == 1);
    ps2_bit(1'b0, 1'b0, d, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i], 1'b0, d, 1'b0, 1'b0);
    ps2_bit(p, 1'b0, d, 1'b0, 1'b0);
    ps2_bit(stop_bit, 1'b1, d, good, pop_stop);
  endtask

  task automatic send_partial(input logic [7:0] d, input int nbits);
    ps2_bit(1'b0, 1'b0, d, 1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) ps2_bit(d[i], 1'b0, d, 1'b0, 1'b0);
  endtask

  task automatic drain();
    rx_ready = 1'b1;
    repeat (12) step();
    chk("drained_rx_valid", rx_valid, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; enable = 1'b1;
    cfg_we = 1'b0; cfg_wdata = 6'h00; rx_ready = 1'b0;
    repeat (3) step();
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_synch_en", synch_en, 1'b1);
    chk("rst_deb_time", deb_time, 5'd4);
    rst_n  = 1'b1;
    mon_on = 1'b1;
    step();

    // Good frame with host ready.
    rx_ready = 1'b1;
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
    step();
    chk("busy_after_stop", busy, 1'b0);
    repeat (4) step();

    // Bad parity, then bad stop bit.
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    repeat (4) step();

    // Overflow on the fifth byte with host stalled.
    rx_ready = 1'b0;
    for (int k = 1; k <= 5; k++) send_frame(8'(k), 1'b1, 1'b1, 1'b0);
    repeat (3) step();
    chk("full_rx_valid", rx_valid, 1'b1);
    drain();

    // Push and pop in the same cycle while full.
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b1, 1'b0);
    send_frame(8'h33, 1'b1, 1'b1, 1'b0);
    send_frame(8'h44, 1'b1, 1'b1, 1'b0);
    send_frame(8'h55, 1'b1, 1'b1, 1'b1);
    repeat (3) step();
    drain();

    // Config write mid-frame aborts silently.
    send_partial(8'h5A, 4);
    chk("busy_mid_frame", busy, 1'b1);
    cfg_wdata = 6'h23;
    cfg_we    = 1'b1;
    step();
    cfg_we = 1'b0;
    chk("cfg_synch_en", synch_en, 1'b1);
    chk("cfg_deb_time", deb_time, 5'd3);
    chk("cfg_busy", busy, 1'b0);
    send_frame(8'h12, 1'b1, 1'b1, 1'b0);
    repeat (4) step();

    // Idle fall with data high, then enable drop mid-frame.
    ps2_bit(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step();
    chk("idle_high_busy", busy, 1'b0);
    send_partial(8'hC3, 5);
    chk("busy_before_disable", busy, 1'b1);
    enable = 1'b0;
    step();
    enable = 1'b1;
    chk("disable_busy", busy, 1'b0);
    send_frame(8'h7E, 1'b1, 1'b1, 1'b0);
    repeat (4) step();

    // Randomised frames, errors, config writes and host stalls.
    rand_ready = 1'b1;
    for (int n = 0; n < 30; n++) begin
      int unsigned r;
      logic [31:0] w;
      r = $urandom_range(0, 9);
      w = $urandom;
      if (r == 0) begin
        cfg_wdata = w[5:0];
        cfg_we    = 1'b1;
        step();
        cfg_we = 1'b0;
        chk("rand_synch_en", synch_en, w[5]);
        chk("rand_deb_time", deb_time, w[4:0]);
      end else begin
        send_frame(w[7:0], r > 2, r != 1, 1'b0);
      end
    end
    rand_ready = 1'b0;
    step();
    drain();

    // A stalled partial frame stays in progress without error.
    send_partial(8'h81, 3);
    repeat (300) step();
    chk("stall_busy", busy, 1'b1);
    enable = 1'b0;
    step();
    enable = 1'b1;
    chk("stall_abort_busy", busy, 1'b0);
    repeat (5) step();

    mon_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_rx_controller.md
Name: ps2_rx_controller

Overview:
Receive-side controller for the PS/2 front end. Drives the signal-conditioning configuration (synchroniser enable, debounce time) from a register write port. Consumes the conditioned PS/2 clock and data lines, detects falling clock edges and sequences the 11-bit frame: start, 8 data bits LSB-first, odd parity, stop. Validated bytes are buffered in a small FIFO and delivered to the host over a valid/ready handshake.

Parameters:
FIFO_DEPTH, 4, receive FIFO entries; power of 2, minimum 2.
DEB_RESET, 5'd4, reset value of the deb_time output.
TIMEOUT_CYCLES, 50000, clk cycles without a falling edge before a partial frame is aborted (used only with PS2_RX_TIMEOUT_EN).

Ports:
clk  in  1  system clock; single clock domain.
rst_n  in  1  synchronous, active-low reset.
ps2_clk  in  1  conditioned PS/2 clock (debounced/synchronised CLK).
ps2_data  in  1  conditioned PS/2 data.
enable  in  1  receiver enable; low forces IDLE.
cfg_we  in  1  configuration write strobe.
cfg_wdata  in  6  [5]=synch_en, [4:0]=deb_time.
synch_en  out  1  to conditioning block SYNCH_EN.
deb_time  out  5  to conditioning block DEB_TIME.
rx_data  out  8  FIFO head byte.
rx_valid  out  1  FIFO not empty.
rx_ready  in  1  host accepts rx_data when rx_valid & rx_ready.
busy  out  1  frame in progress (state != IDLE).
frame_err  out  1  one-cycle pulse on parity, stop or timeout error.
overflow  out  1  one-cycle pulse when a good byte is dropped because the FIFO is full.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, FIFO empty, rx_valid=0, rx_data=0, busy=0, frame_err=0, overflow=0.
  - synch_en=1, deb_time=DEB_RESET.
  - Previous-clock register=1, so no false edge is seen after reset.
  - A reset mid-frame discards the partial frame.
- Edge detect: fall = prev_clk & ~ps2_clk. prev_clk is registered every cycle. ps2_data is sampled in the same cycle fall is seen.
- FSM, all transitions on fall only:
  - IDLE: data=0 -> DATA, bit_cnt=0. data=1 -> stay in IDLE; no error.
  - DATA: shreg <= {data, shreg[7:1]}, bit_cnt++. After the 8th bit -> PARITY.
  - PARITY: latch p -> STOP.
  - STOP: if data=1 and ^{shreg,p}=1, the byte is good. Push it, or pulse overflow if the FIFO is full. Otherwise pulse frame_err. Always -> IDLE.
- Latency: rx_valid rises (when the FIFO was empty) 1 clk after the cycle in which the stop-bit fall is seen. frame_err and overflow pulse in that same cycle.
- enable=0: state is forced to IDLE every cycle and the partial frame is discarded silently. FIFO contents and pops are unaffected.
- cfg_we=1:
  - synch_en and deb_time update at the next edge.
  - The same edge forces IDLE and discards any partial frame, with no frame_err.
  - cfg_we takes priority over a simultaneous fall.
- FIFO:
  - Circular buffer; pointers wrap modulo FIFO_DEPTH. Count width is log2(FIFO_DEPTH)+1.
  - rx_data shows the head entry combinationally from the storage array.
  - Push and pop in the same cycle: count unchanged. This includes the full case: when full, the pop frees a slot and the push is accepted with no overflow.
  - When empty, a push and an rx_ready in the same cycle do not bypass: the byte appears next cycle.
- Pulse outputs are never asserted for more than one consecutive cycle per event.

Optional Feature:
Macro PS2_RX_TIMEOUT_EN.
- Defined:
  - A counter clears on every fall and on entry to IDLE, and increments while state != IDLE.
  - Reaching TIMEOUT_CYCLES-1 forces IDLE and pulses frame_err next cycle.
  - A fall in the same cycle takes priority and clears the counter.
- Not defined: no counter; a partial frame waits indefinitely for edges; no timeout errors.

Test Plan:
- Frame start0, 0xA5 LSB-first, p=1, stop1 with rx_ready=1 -> rx_valid for 1 cycle with rx_data=0xA5, no frame_err, busy low after the stop bit.
- Frame 0x3C with p=0 (bad parity) -> frame_err pulses once, rx_valid stays 0. Repeat with good parity but stop=0 -> frame_err, nothing pushed.
- rx_ready=0, send 0x01,0x02,0x03,0x04,0x05 (FIFO_DEPTH=4) -> overflow pulses on the 5th byte. Popping then yields 01,02,03,04 and rx_valid drops. Also pop in the same cycle as a push while full -> no overflow, count stays 4.
- After 4 data bits of a frame, pulse cfg_we with 6'h23 -> synch_en=1, deb_time=3, busy=0 next cycle, no frame_err. A following full frame 0x12 is received correctly.
- Falling edge with data=1 in IDLE -> state stays IDLE, no error. enable=0 mid-frame -> frame discarded. The next frame 0x7E after enable=1 is received.
- With PS2_RX_TIMEOUT_EN, TIMEOUT_CYCLES=100: stop edges after 3 data bits -> frame_err pulses exactly 100 cycles after the last fall, busy=0. Without the macro -> busy stays 1, no error.
